// File: rtl/bp_share_arbiter_if.sv
// ============================================================================
//  Module      : bp_share_arbiter_if
//  Description : One requester channel of the shared branch-predictor
//                arbiter: an update request (valid/id/outcome), the
//                acceptance strobe, and the one-cycle miss response.
//                master = requester side, slave = arbiter side.
//  Signals     : req_valid   requester has an update pending
//                req_id      branchID of the pending update
//                req_outcome resolved outcome (1 = taken)
//                req_ready   update accepted this cycle
//                resp_valid  response pulse, one cycle after acceptance
//                resp_miss   predictor miss for that update
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bp_share_arbiter_if #(
  parameter int ID_W = 3
);
  logic            req_valid;
  logic [ID_W-1:0] req_id;
  logic            req_outcome;
  logic            req_ready;
  logic            resp_valid;
  logic            resp_miss;

  modport master (
    output req_valid,
    output req_id,
    output req_outcome,
    input  req_ready,
    input  resp_valid,
    input  resp_miss
  );

  modport slave (
    input  req_valid,
    input  req_id,
    input  req_outcome,
    output req_ready,
    output resp_valid,
    output resp_miss
  );
endinterface

`default_nettype wire

// File: rtl/bp_share_arbiter.sv
// ============================================================================
//  Module      : bp_share_arbiter
//  Description : Shares one branch predictor between two branch-outcome
//                streams. After reset the predictor's reset line is held
//                for INIT_CYCLES cycles, then at most one update per cycle
//                is granted using round-robin priority. Each update's miss
//                result is returned to its requester one cycle later, and
//                per-requester access/miss counters are kept.
//  Ports       : clk, reset          clock, synchronous active-high reset
//                req0_if, req1_if    requester channels (slave modport)
//                pred_*_o, pred_miss_i
//                                    predictor drive and combinational miss
//                clear_counts_i      synchronous clear of all counters
//                acc*/miss*_count_o  saturating per-requester counters
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_share_arbiter #(
  parameter int ID_W        = 3,
  parameter int CNT_W       = 16,
  parameter int INIT_CYCLES = 5   // must be at least 1
) (
  input  logic              clk,
  input  logic              reset,

  bp_share_arbiter_if.slave req0_if,
  bp_share_arbiter_if.slave req1_if,

  output logic              pred_reset_o,
  output logic [ID_W-1:0]   pred_branchID_o,
  output logic              pred_outcome_o,
  output logic              pred_update_o,
  input  logic              pred_miss_i,

  input  logic              clear_counts_i,
  output logic [CNT_W-1:0]  acc0_count_o,
  output logic [CNT_W-1:0]  acc1_count_o,
  output logic [CNT_W-1:0]  miss0_count_o,
  output logic [CNT_W-1:0]  miss1_count_o
);

  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [INIT_W-1:0]  init_cnt_q, init_cnt_d;
  logic               rr_q, rr_d;          // index of the requester with priority
  logic               resp0_valid_q, resp0_valid_d;
  logic               resp0_miss_q, resp0_miss_d;
  logic               resp1_valid_q, resp1_valid_d;
  logic               resp1_miss_q, resp1_miss_d;
  logic [CNT_W-1:0]   acc0_q, acc0_d;
  logic [CNT_W-1:0]   acc1_q, acc1_d;
  logic [CNT_W-1:0]   miss0_q, miss0_d;
  logic [CNT_W-1:0]   miss1_q, miss1_d;

  logic               run;
  logic               grant_valid;
  logic               grant_idx;
  logic               grant0;
  logic               grant1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val,
                                               input logic             inc);
    if (inc && (val != {CNT_W{1'b1}})) begin
      return val + CNT_W'(1);
    end
    return val;
  endfunction

  // --------------------------------------------------------------------------
  // Grant selection: requests are ignored entirely while the predictor is
  // still in its reset sequence.
  // --------------------------------------------------------------------------
  always_comb begin
    run         = (state_q == ST_RUN);
    grant_valid = 1'b0;
    grant_idx   = 1'b0;
    if (run) begin
      if (req0_if.req_valid && req1_if.req_valid) begin
        grant_valid = 1'b1;
        grant_idx   = rr_q;
      end else if (req0_if.req_valid) begin
        grant_valid = 1'b1;
        grant_idx   = 1'b0;
      end else if (req1_if.req_valid) begin
        grant_valid = 1'b1;
        grant_idx   = 1'b1;
      end
    end
    grant0 = grant_valid && !grant_idx;
    grant1 = grant_valid &&  grant_idx;
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    rr_d          = rr_q;
    resp0_valid_d = grant0;
    resp0_miss_d  = grant0 && pred_miss_i;
    resp1_valid_d = grant1;
    resp1_miss_d  = grant1 && pred_miss_i;
    acc0_d        = sat_inc(acc0_q,  grant0);
    acc1_d        = sat_inc(acc1_q,  grant1);
    miss0_d       = sat_inc(miss0_q, grant0 && pred_miss_i);
    miss1_d       = sat_inc(miss1_q, grant1 && pred_miss_i);

    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          state_d    = ST_RUN;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + INIT_W'(1);
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d    = ST_INIT;
        init_cnt_d = '0;
      end
    endcase

    // After a grant the other requester gets priority next time.
    if (grant_valid) begin
      rr_d = !grant_idx;
    end

    // A clear wins over an increment landing on the same edge.
    if (clear_counts_i) begin
      acc0_d  = '0;
      acc1_d  = '0;
      miss0_d = '0;
      miss1_d = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_INIT;
      init_cnt_q    <= '0;
      rr_q          <= 1'b0;
      resp0_valid_q <= 1'b0;
      resp0_miss_q  <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp1_miss_q  <= 1'b0;
      acc0_q        <= '0;
      acc1_q        <= '0;
      miss0_q       <= '0;
      miss1_q       <= '0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      rr_q          <= rr_d;
      resp0_valid_q <= resp0_valid_d;
      resp0_miss_q  <= resp0_miss_d;
      resp1_valid_q <= resp1_valid_d;
      resp1_miss_q  <= resp1_miss_d;
      acc0_q        <= acc0_d;
      acc1_q        <= acc1_d;
      miss0_q       <= miss0_d;
      miss1_q       <= miss1_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign req0_if.req_ready  = grant0;
  assign req1_if.req_ready  = grant1;
  assign req0_if.resp_valid = resp0_valid_q;
  assign req0_if.resp_miss  = resp0_miss_q;
  assign req1_if.resp_valid = resp1_valid_q;
  assign req1_if.resp_miss  = resp1_miss_q;

  assign pred_reset_o    = !run;
  assign pred_update_o   = grant_valid;
  assign pred_branchID_o = grant0 ? req0_if.req_id      :
                           grant1 ? req1_if.req_id      : '0;
  assign pred_outcome_o  = grant0 ? req0_if.req_outcome :
                           grant1 ? req1_if.req_outcome : 1'b0;

  assign acc0_count_o  = acc0_q;
  assign acc1_count_o  = acc1_q;
  assign miss0_count_o = miss0_q;
  assign miss1_count_o = miss1_q;

endmodule

`default_nettype wire
